// File: rtl/operand_fetch_seq_if.sv
// operand_fetch_seq_if: decode-side start/operand signals and the
// shared 8-bit memory bus, grouped for the operand fetch sequencer.
interface operand_fetch_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              i_start;
  logic [2:0]        i_mode;
  logic [ADDR_W-1:0] i_pc;
  logic [DATA_W-1:0] i_x;
  logic [DATA_W-1:0] i_y;
  logic [DATA_W-1:0] i_rdata;
  logic [ADDR_W-1:0] o_addr;
  logic              o_rd;
  logic              o_pc_inc;
  logic [DATA_W-1:0] o_operand;
  logic [ADDR_W-1:0] o_eff_addr;
  logic              o_page_cross;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_mode, i_pc, i_x, i_y, i_rdata,
    input  o_addr, o_rd, o_pc_inc, o_operand,
    input  o_eff_addr, o_page_cross, o_busy, o_done
  );

  modport slave (
    input  i_start, i_mode, i_pc, i_x, i_y, i_rdata,
    output o_addr, o_rd, o_pc_inc, o_operand,
    output o_eff_addr, o_page_cross, o_busy, o_done
  );
endinterface

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: 6502 operand fetch / effective address sequencer.
// Optional macro OFS_PAGE_CROSS_CYCLE_EN adds the ABX/ABY page-fix cycle.
module operand_fetch_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  operand_fetch_seq_if.slave bus
);

  localparam int HW = ADDR_W - DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_INDEX,
    S_FIX_HI, S_READ_OP, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_IMM, M_ZP, M_ZPX, M_ABS,
    M_ABX, M_ABY, M_ZPY, M_IMP
  } mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0] eff_q, eff_d;
  logic              pg_q, pg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              pc_inc;
  logic [DATA_W-1:0] idx;
  logic [DATA_W:0]   sum;

  // Y indexes ABY/ZPY, X everything else; low-byte add keeps its carry
  always_comb begin
    idx = ((mode_q == M_ABY) || (mode_q == M_ZPY)) ? y_q : x_q;
    sum = {1'b0, lo_q} + {1'b0, idx};
  end

  // Next-state, bus cycle and datapath update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pc_d    = pc_q;
    x_d     = x_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    op_d    = op_q;
    eff_d   = eff_q;
    pg_d    = pg_q;
    rd      = 1'b0;
    pc_inc  = 1'b0;
    addr    = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          mode_d = mode_t'(bus.i_mode);
          pc_d   = bus.i_pc;
          x_d    = bus.i_x;
          y_d    = bus.i_y;
          pg_d   = 1'b0;
          if (mode_t'(bus.i_mode) == M_IMP) begin
            op_d    = '0;
            eff_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH_LO;
          end
        end
      end
      S_FETCH_LO: begin
        rd     = 1'b1;
        pc_inc = 1'b1;
        addr   = pc_q;
        lo_d   = bus.i_rdata;
        unique case (mode_q)
          M_IMM: begin
            op_d    = bus.i_rdata;
            eff_d   = pc_q;
            state_d = S_DONE;
          end
          M_ZP: begin
            eff_d   = {{HW{1'b0}}, bus.i_rdata};
            state_d = S_READ_OP;
          end
          M_ZPX, M_ZPY: state_d = S_INDEX;
          default:      state_d = S_FETCH_HI;
        endcase
      end
      S_FETCH_HI: begin
        rd     = 1'b1;
        pc_inc = 1'b1;
        addr   = pc_q + ADDR_W'(1);
        hi_d   = bus.i_rdata;
        if (mode_q == M_ABS) begin
          eff_d   = {bus.i_rdata, lo_q};
          state_d = S_READ_OP;
        end else begin
          eff_d = {bus.i_rdata, lo_q} + {{HW{1'b0}}, idx};
          pg_d  = sum[DATA_W];
`ifdef OFS_PAGE_CROSS_CYCLE_EN
          state_d = sum[DATA_W] ? S_FIX_HI : S_READ_OP;
`else
          state_d = S_READ_OP;
`endif
        end
      end
      S_INDEX: begin
        rd      = 1'b1;
        addr    = {{HW{1'b0}}, lo_q};
        eff_d   = {{HW{1'b0}}, sum[DATA_W-1:0]};
        state_d = S_READ_OP;
      end
      S_FIX_HI: begin
        rd      = 1'b1;
        addr    = {hi_q, eff_q[DATA_W-1:0]};
        state_d = S_READ_OP;
      end
      S_READ_OP: begin
        rd      = 1'b1;
        addr    = eff_q;
        op_d    = bus.i_rdata;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    addr_d = addr;
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_IMM;
      pc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      op_q    <= '0;
      eff_q   <= '0;
      pg_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pc_q    <= pc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      op_q    <= op_d;
      eff_q   <= eff_d;
      pg_q    <= pg_d;
      addr_q  <= addr_d;
    end
  end

  // Bus and status outputs
  always_comb begin
    bus.o_addr       = addr;
    bus.o_rd         = rd;
    bus.o_pc_inc     = pc_inc;
    bus.o_operand    = op_q;
    bus.o_eff_addr   = eff_q;
    bus.o_page_cross = pg_q;
    bus.o_busy       = (state_q != S_IDLE);
    bus.o_done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: directed and randomized checks of the
// operand fetch sequencer against a memory-level reference model.
module tb_operand_fetch_seq;

`ifdef OFS_PAGE_CROSS_CYCLE_EN
  localparam bit PX = 1'b1;
`else
  localparam bit PX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_seq_if ifc ();

  operand_fetch_seq dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  logic [7:0] mem [0:65535];
  assign ifc.i_rdata = mem[ifc.o_addr];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] rd_q[$];
  logic [15:0] exp_rd[$];
  int pcinc_n = 0;
  int done_n  = 0;
  int lat;

  logic [7:0]  exp_op;
  logic [15:0] exp_eff;
  logic        exp_pg;
  int          exp_pcinc;
  int          exp_lat;

  always @(negedge clk) begin
    if (ifc.o_rd) rd_q.push_back(ifc.o_addr);
    if (ifc.o_pc_inc) pcinc_n++;
    if (ifc.o_done) done_n++;
  end

  function automatic bit reads_match();
    if (rd_q.size() != exp_rd.size()) return 1'b0;
    foreach (rd_q[i])
      if (rd_q[i] !== exp_rd[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input logic [15:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  // Expected bus trace and results from the addressing-mode rules
  task automatic model(input int m, input int pc, input int x,
                       input int y);
    int idx, lo, hi, base, eff;
    idx = (m == 5 || m == 6) ? y : x;
    exp_rd.delete();
    exp_pg = 1'b0;
    exp_op = 8'h00;
    exp_eff = 16'h0000;
    exp_pcinc = 0;
    lo = mem[pc];
    hi = mem[(pc + 1) % 65536];
    case (m)
      7: ;
      0: begin
        exp_rd.push_back(16'(pc));
        exp_op = mem[pc];
        exp_eff = 16'(pc);
        exp_pcinc = 1;
      end
      1, 2, 6: begin
        exp_rd.push_back(16'(pc));
        if (m == 1) eff = lo;
        else begin
          exp_rd.push_back(16'(lo));
          eff = (lo + idx) % 256;
        end
        exp_rd.push_back(16'(eff));
        exp_eff = 16'(eff);
        exp_op = mem[eff];
        exp_pcinc = 1;
      end
      default: begin
        exp_rd.push_back(16'(pc));
        exp_rd.push_back(16'((pc + 1) % 65536));
        base = hi * 256 + lo;
        if (m == 3) eff = base;
        else begin
          eff = (base + idx) % 65536;
          exp_pg = (lo + idx) > 255;
          if (exp_pg && PX)
            exp_rd.push_back(16'(hi * 256 + (lo + idx) % 256));
        end
        exp_rd.push_back(16'(eff));
        exp_eff = 16'(eff);
        exp_op = mem[eff];
        exp_pcinc = 2;
      end
    endcase
    exp_lat = exp_rd.size() + 1;
  endtask

  // Launch one operation, scramble inputs after start, wait for done
  task automatic run_op(input logic [2:0] m, input logic [15:0] pc,
                        input logic [7:0] x, input logic [7:0] y,
                        input bit extra_start);
    @(posedge clk);
    #1;
    rd_q.delete();
    pcinc_n = 0;
    done_n = 0;
    ifc.i_mode = m;
    ifc.i_pc = pc;
    ifc.i_x = x;
    ifc.i_y = y;
    ifc.i_start = 1'b1;
    @(posedge clk);
    #1;
    ifc.i_start = 1'b0;
    ifc.i_mode = 3'($urandom);
    ifc.i_pc = 16'($urandom);
    ifc.i_x = 8'($urandom);
    ifc.i_y = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (extra_start && lat == 1) ifc.i_start = 1'b1;
      if (extra_start && lat == 2) ifc.i_start = 1'b0;
    end while (!ifc.o_done && lat < 20);
    ifc.i_start = 1'b0;
    n_cmp++;
    if (ifc.o_done !== 1'b1) begin
      n_err++;
      $display("FAIL timeout: o_done=%b after %0d cycles, need 1",
               ifc.o_done, lat);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ifc.o_rd, ifc.o_pc_inc, ifc.o_page_cross, ifc.o_busy,
         ifc.o_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b need 00000",
               {ifc.o_rd, ifc.o_pc_inc, ifc.o_page_cross, ifc.o_busy,
                ifc.o_done});
    end
    n_cmp++;
    if (ifc.o_addr !== 16'h0) begin
      n_err++;
      $display("FAIL reset_addr: got %h need 0000", ifc.o_addr);
    end
    n_cmp++;
    if ({ifc.o_operand, ifc.o_eff_addr} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h need 00/0000",
               ifc.o_operand, ifc.o_eff_addr);
    end
  endtask

  task automatic test_imm();
    mem[16'h0200] = 8'h42;
    run_op(3'd0, 16'h0200, 8'h00, 8'h00, 1'b0);
    exp_rd = '{16'h0200};
    n_cmp++;
    if (reads_match() !== 1'b1) begin
      n_err++;
      $display("FAIL imm_reads: got %s need %s", q2s(rd_q), q2s(exp_rd));
    end
    n_cmp++;
    if (lat !== 2 || pcinc_n !== 1) begin
      n_err++;
      $display("FAIL imm_timing: lat=%0d pcinc=%0d need 2/1", lat, pcinc_n);
    end
    n_cmp++;
    if (ifc.o_operand !== 8'h42 || ifc.o_eff_addr !== 16'h0200) begin
      n_err++;
      $display("FAIL imm_result: got %h/%h need 42/0200",
               ifc.o_operand, ifc.o_eff_addr);
    end
  endtask

  task automatic test_zpx();
    mem[16'h0300] = 8'hF0;
    mem[16'h0010] = 8'h77;
    run_op(3'd2, 16'h0300, 8'h20, 8'h00, 1'b0);
    exp_rd = '{16'h0300, 16'h00F0, 16'h0010};
    n_cmp++;
    if (reads_match() !== 1'b1) begin
      n_err++;
      $display("FAIL zpx_reads: got %s need %s", q2s(rd_q), q2s(exp_rd));
    end
    n_cmp++;
    if (ifc.o_operand !== 8'h77 || ifc.o_eff_addr !== 16'h0010 ||
        lat !== 4) begin
      n_err++;
      $display("FAIL zpx_result: got %h/%h lat %0d need 77/0010 lat 4",
               ifc.o_operand, ifc.o_eff_addr, lat);
    end
  endtask

  task automatic test_abx_cross();
    mem[16'h0400] = 8'hFF;
    mem[16'h0401] = 8'h12;
    mem[16'h1300] = 8'hAB;
    run_op(3'd4, 16'h0400, 8'h01, 8'h00, 1'b0);
    if (PX) exp_rd = '{16'h0400, 16'h0401, 16'h1200, 16'h1300};
    else    exp_rd = '{16'h0400, 16'h0401, 16'h1300};
    n_cmp++;
    if (reads_match() !== 1'b1) begin
      n_err++;
      $display("FAIL abx_reads: got %s need %s", q2s(rd_q), q2s(exp_rd));
    end
    n_cmp++;
    if (ifc.o_page_cross !== 1'b1 || ifc.o_operand !== 8'hAB ||
        ifc.o_eff_addr !== 16'h1300) begin
      n_err++;
      $display("FAIL abx_result: got pg=%b %h/%h need 1 AB/1300",
               ifc.o_page_cross, ifc.o_operand, ifc.o_eff_addr);
    end
  endtask

  task automatic test_abs_wrap_busy_start();
    logic [7:0] r;
    r = 8'($urandom);
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h1234] = r;
    run_op(3'd3, 16'hFFFF, 8'h00, 8'h00, 1'b1);
    exp_rd = '{16'hFFFF, 16'h0000, 16'h1234};
    n_cmp++;
    if (reads_match() !== 1'b1) begin
      n_err++;
      $display("FAIL abs_wrap_reads: got %s need %s",
               q2s(rd_q), q2s(exp_rd));
    end
    n_cmp++;
    if (ifc.o_operand !== r || ifc.o_eff_addr !== 16'h1234) begin
      n_err++;
      $display("FAIL abs_wrap_result: got %h/%h need %h/1234",
               ifc.o_operand, ifc.o_eff_addr, r);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifc.o_busy !== 1'b0 || done_n !== 1) begin
      n_err++;
      $display("FAIL busy_start_ignored: busy=%b dones=%0d need 0/1",
               ifc.o_busy, done_n);
    end
    n_cmp++;
    if (ifc.o_operand !== r || ifc.o_addr !== 16'h1234 ||
        ifc.o_rd !== 1'b0) begin
      n_err++;
      $display("FAIL hold: got op=%h addr=%h rd=%b need %h/1234/0",
               ifc.o_operand, ifc.o_addr, ifc.o_rd, r);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    done_n = 0;
    ifc.i_mode = 3'd3;
    ifc.i_pc = 16'h0500;
    ifc.i_start = 1'b1;
    @(posedge clk);
    #1;
    ifc.i_start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ifc.o_busy !== 1'b1 || ifc.o_addr !== 16'h0501) begin
      n_err++;
      $display("FAIL mid_prereset: busy=%b addr=%h need 1/0501",
               ifc.o_busy, ifc.o_addr);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.o_busy, ifc.o_rd, ifc.o_done, ifc.o_pc_inc} !== 4'b0 ||
        ifc.o_addr !== 16'h0 || ifc.o_eff_addr !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset: ctl=%b addr=%h eff=%h need 0000/0/0",
               {ifc.o_busy, ifc.o_rd, ifc.o_done, ifc.o_pc_inc},
               ifc.o_addr, ifc.o_eff_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_n !== 0 || ifc.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_nodone: dones=%0d busy=%b need 0/0",
               done_n, ifc.o_busy);
    end
    mem[16'h0600] = 8'h5A;
    run_op(3'd0, 16'h0600, 8'h00, 8'h00, 1'b0);
    n_cmp++;
    if (ifc.o_operand !== 8'h5A || lat !== 2) begin
      n_err++;
      $display("FAIL post_reset_imm: got %h lat %0d need 5a lat 2",
               ifc.o_operand, lat);
    end
  endtask

  task automatic test_random();
    int m, pc, x, y;
    for (int i = 0; i < 60; i++) begin
      m  = $urandom_range(0, 7);
      pc = $urandom_range(0, 65535);
      x  = $urandom_range(0, 255);
      y  = $urandom_range(0, 255);
      if (i % 4 == 0) pc = 16'hFFFF;
      model(m, pc, x, y);
      run_op(3'(m), 16'(pc), 8'(x), 8'(y), 1'b0);
      n_cmp++;
      if (reads_match() !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_reads m%0d: got %s need %s",
                 m, q2s(rd_q), q2s(exp_rd));
      end
      n_cmp++;
      if (lat !== exp_lat || pcinc_n !== exp_pcinc) begin
        n_err++;
        $display("FAIL rnd_timing m%0d: lat=%0d pcinc=%0d need %0d/%0d",
                 m, lat, pcinc_n, exp_lat, exp_pcinc);
      end
      n_cmp++;
      if (ifc.o_operand !== exp_op || ifc.o_eff_addr !== exp_eff ||
          ifc.o_page_cross !== exp_pg) begin
        n_err++;
        $display("FAIL rnd_result m%0d: got %h/%h/%b need %h/%h/%b",
                 m, ifc.o_operand, ifc.o_eff_addr, ifc.o_page_cross,
                 exp_op, exp_eff, exp_pg);
      end
    end
  endtask

  initial begin
    ifc.i_start = 1'b0;
    ifc.i_mode = 3'd0;
    ifc.i_pc = 16'h0;
    ifc.i_x = 8'h0;
    ifc.i_y = 8'h0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #1;
    test_reset();
    #12 rst = 1'b0;
    test_imm();
    test_zpx();
    test_abx_cross();
    test_abs_wrap_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch_seq.md
Name: operand_fetch_seq

Overview:
- Sequences the bus cycles the 6502 core needs after opcode decode: fetches operand bytes from the PC stream, forms the effective address for the selected addressing mode, and reads the data operand.
- Sits between the core's decode stage and the shared 8-bit memory bus.
- Delivers a final operand byte and a 16-bit effective address to the ALU/EXECUTE stage with a done pulse.

Parameters:
- ADDR_W, 16, address bus width (only 16 is supported).
- DATA_W, 8, data bus width (only 8 is supported).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  begin operand fetch; sampled only in IDLE.
- i_mode  in  3  addressing mode: 0 IMM, 1 ZP, 2 ZPX, 3 ABS, 4 ABX, 5 ABY, 6 ZPY, 7 IMP.
- i_pc  in  16  address of first operand byte (opcode address + 1); latched at start.
- i_x  in  8  X index; latched at start.
- i_y  in  8  Y index; latched at start.
- i_rdata  in  8  bus read data; valid in the same cycle o_addr is driven, sampled at the closing rising edge.
- o_addr  out  16  bus address.
- o_rd  out  1  1 = bus read cycle in progress (maps to core read_write = 1).
- o_pc_inc  out  1  one-cycle pulse per operand byte consumed from the PC stream.
- o_operand  out  8  fetched operand byte.
- o_eff_addr  out  16  computed effective address.
- o_page_cross  out  1  ABX/ABY index add carried into the high byte.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse; operand and effective address are valid.

Behaviour:
- Reset (async): state IDLE. o_addr, o_operand and o_eff_addr = 0. o_rd, o_pc_inc, o_page_cross, o_busy and o_done = 0.
- States: IDLE, FETCH_LO, FETCH_HI, INDEX, FIX_HI, READ_OP, DONE.
- Start:
  - i_start in IDLE latches mode, pc_l, x_l and y_l.
  - Next state is FETCH_LO, except IMP, which goes straight to DONE.
  - i_start outside IDLE is ignored.
- FETCH_LO: o_addr = pc_l, o_rd = 1, o_pc_inc = 1; capture lo. Next state:
  - IMM: operand = i_rdata, eff = pc_l, go to DONE.
  - ZP: go to READ_OP.
  - ZPX / ZPY: go to INDEX.
  - ABS / ABX / ABY: go to FETCH_HI.
- FETCH_HI: o_addr = pc_l + 1 (16-bit wrap), o_rd = 1, o_pc_inc = 1; capture hi.
  - ABS: eff = {hi, lo}, go to READ_OP.
  - ABX / ABY: sum = lo + idx (9 bits); eff = {hi, lo} + idx (16-bit wrap); o_page_cross = sum[8].
  - ABX / ABY next state: FIX_HI if page cross and the macro is defined, else READ_OP.
- INDEX:
  - Dummy read at {8'h00, lo}, o_rd = 1.
  - eff = {8'h00, (lo + idx)[7:0]}, so zero page wraps and never carries into page 1.
  - Next state READ_OP.
- FIX_HI: dummy read at {hi, sum[7:0]} (uncorrected page), o_rd = 1; next state READ_OP.
- READ_OP: o_addr = eff, o_rd = 1, operand = i_rdata; next state DONE.
- DONE: o_done = 1, o_rd = 0; next state IDLE.
- Outputs outside an active read cycle: o_rd = 0, o_addr holds its last value.
- Bus-cycle counts, start edge to o_done:
  - IMP 0 (done 1 cycle after the start edge).
  - IMM 1, ZP 2, ZPX/ZPY 3, ABS 3, ABX/ABY 3, or 4 on page cross.
  - o_done follows the last bus cycle by 1 cycle.
- Output hold:
  - o_operand, o_eff_addr and o_page_cross hold until the next accepted start.
  - o_page_cross clears at start.
  - IMP drives o_operand = 0 and o_eff_addr = 0.
- PC wrap: pc_l = 16'hFFFF fetches hi from 16'h0000.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no o_done is produced.
- i_mode is ignored after start; changes during an operation have no effect.

Optional Feature:
- Macro OFS_PAGE_CROSS_CYCLE_EN.
- Defined: ABX/ABY page cross inserts FIX_HI (dummy read at uncorrected address, +1 cycle), matching 6502 timing.
- Undefined: FIX_HI is never entered. ABX/ABY always take 3 bus cycles. o_page_cross is still reported.

Test Plan:
- IMM, i_pc = 16'h0200, mem[0200] = 8'h42 -> one read at 0200, o_pc_inc = 1 once, o_done 2 cycles after start, o_operand = 42, o_eff_addr = 0200.
- ZPX, i_pc = 16'h0300, mem[0300] = 8'hF0, X = 8'h20, mem[0010] = 8'h77:
  - reads in order 0300, 00F0, 0010;
  - o_eff_addr = 0010, o_operand = 77.
- ABX, mem[0400] = 8'hFF, mem[0401] = 8'h12, X = 8'h01, mem[1300] = 8'hAB, macro defined:
  - reads in order 0400, 0401, 1200, 1300;
  - o_page_cross = 1, o_operand = AB, 4 bus cycles.
- Same ABX test with macro undefined -> reads 0400, 0401, 1300; 3 bus cycles; o_page_cross = 1.
- ABS at i_pc = 16'hFFFF with mem[FFFF] = 8'h34, mem[0000] = 8'h12 -> hi fetched from 0000, read at 1234. Second i_start pulsed during busy is ignored.
- Assert i_rst during FETCH_HI of an ABS op -> o_busy, o_rd and o_done = 0 immediately. The next IMM start completes normally.
